// File: rtl/src_stream_gen.sv
// Buffer-RAM to stream transmitter: NB+1 frames of LEN+1 words, src_last on each frame end.
// First mem_re 1 clk after start, first src_valid 2 clks later; 2-entry FIFO absorbs src_ready stalls.
module src_stream_gen #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [11:0]   len,
  input  logic [3:0]    nb,
  input  logic          abort,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_last,
  input  logic          src_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [11:0]   len_q, len_d, wi_q, wi_d;
  logic [3:0]    nb_q, nb_d, fi_q, fi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW:0]   ent0_q, ent0_d, ent1_q, ent1_d;

  logic pop, push, issue, wi_last, fi_last, drained, aborting;
  logic [DW:0] push_ent;

  assign pop      = (cnt_q != 2'd0) && src_ready;
  assign push     = infl_q;
  assign push_ent = {infl_last_q, mem_rdata};
  assign wi_last  = (wi_q == len_q);
  assign fi_last  = (fi_q == nb_q);
  assign drained  = (cnt_q == 2'd0) && !infl_q;
  assign aborting = (state_q != S_IDLE) && abort;
  // Issue only when the read still has a guaranteed FIFO slot on arrival.
  assign issue    = (state_q == S_RUN) &&
                    (({1'b0, cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)                           state_d = S_IDLE;
        else if (issue && wi_last && fi_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (abort || drained) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_re = issue;
    busy   = (state_q != S_IDLE);
    done   = aborting || ((state_q == S_DRAIN) && drained);
  end

  always_comb begin
    len_d       = len_q;
    nb_d        = nb_q;
    wi_d        = wi_q;
    fi_d        = fi_q;
    addr_d      = addr_q;
    infl_d      = issue;
    infl_last_d = wi_last;
    cnt_d       = cnt_q;
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;

    if ((state_q == S_IDLE) && start) begin
      len_d  = len;
      nb_d   = nb;
      addr_d = base;
      wi_d   = 12'd0;
      fi_d   = 4'd0;
    end

    if (issue) begin
      addr_d = addr_q + AW'(1);
      if (wi_last) begin
        wi_d = 12'd0;
        fi_d = fi_q + 4'd1;
      end else begin
        wi_d = wi_q + 12'd1;
      end
    end

    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_ent;
        else               ent1_d = push_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_ent;
        end
      end
      default: ;
    endcase

    // Abort drops both queued words and the read still in flight.
    if (aborting) begin
      cnt_d  = 2'd0;
      infl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      nb_q        <= '0;
      wi_q        <= '0;
      fi_q        <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= '0;
      ent0_q      <= '0;
      ent1_q      <= '0;
    end else begin
      len_q       <= len_d;
      nb_q        <= nb_d;
      wi_q        <= wi_d;
      fi_q        <= fi_d;
      addr_q      <= addr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
    end
  end

  assign mem_addr  = addr_q;
  assign src_valid = (cnt_q != 2'd0);
  assign src_data  = ent0_q[DW-1:0];
  assign src_last  = ent0_q[DW];

endmodule
